tl_ul_slave_q: RTL and testbench
================================

Name: tl_ul_slave_q

Overview:
- Parametrised TileLink-UL slave bridging channel A/D onto a simple single-cycle-strobe register-file port.
- Buffers up to DEPTH requests and echoes source IDs.
- Supports PutFullData, PutPartialData and Get, with denied responses for illegal opcodes or out-of-range addresses.
- Sits between the TL-UL crossbar and a peripheral register bank; one transaction is in service at a time, in strict order.

Parameters:
DW, 32, data width in bits; multiple of 8; mask width MW = DW/8
AW, 4, address width
SW, 4, source ID width
DEPTH, 2, request queue entries (1..8)
RD_LAT, 1, register read latency in cycles from reg_rd strobe to reg_rdata valid (1..4)
REG_NUM, 16, number of implemented register addresses; valid addresses are 0..REG_NUM-1

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
a_valid  input  1  A request valid
a_ready  output  1  A request ready
a_opcode  input  3  0 PutFullData, 1 PutPartialData, 4 Get
a_mask  input  MW  byte lanes
a_address  input  AW  register address
a_source  input  SW  requester ID
a_data  input  DW  write data
d_valid  output  1  D response valid
d_ready  input  1  D response ready
d_opcode  output  3  0 AccessAck, 1 AccessAckData
d_source  output  SW  echoed a_source
d_denied  output  1  request rejected
d_data  output  DW  read data (0 unless AccessAckData and not denied)
reg_wr  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read strobe
reg_addr  output  AW  register address
reg_byte  output  MW  byte enables
reg_wdata  output  DW  write data, disabled lanes zeroed
reg_rdata  input  DW  register read data

Behaviour:
- Reset: all outputs 0, queue emptied, FSM to IDLE, and any in-flight transaction is dropped without a response. a_ready is forced 0 while rst_n is low.
- a_ready = (queue count < DEPTH); combinational from the count.
- A push occurs on a_valid & a_ready. Push and pop in the same cycle leave count unchanged. Push while full is impossible because a_ready is 0.
- A queue entry holds {opcode, mask, address, source, data}. Pops are strict FIFO; the pointers wrap modulo DEPTH.
- Legality per entry:
  - denied = opcode not in {0,1,4}, or address >= REG_NUM.
  - A denied request issues no reg_wr/reg_rd.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head, latch it, and go to ACCESS. On that same edge assert reg_wr (Put, legal) or reg_rd (Get, legal), and drive reg_addr. reg_byte = mask for PutPartial; reg_byte is all ones for PutFull and Get.
  - ACCESS: strobes deassert at the next edge, so they are high for exactly one cycle. Put or denied requests go to RESP. Legal Get goes to WAIT if RD_LAT>1; otherwise reg_rdata is captured and the FSM goes to RESP.
  - WAIT: counts RD_LAT-1 further cycles, captures reg_rdata on the final edge, then goes to RESP.
  - RESP: d_valid=1. d_opcode=1 for Get, 0 otherwise; an illegal opcode gets 0. d_source is the latched source. All D fields stay stable until d_ready. On d_valid & d_ready the FSM goes to IDLE and d_valid clears on that edge.
- Timing:
  - Put: reg_wr high in cycle 1 after the accept edge; d_valid rises at edge 2.
  - Get: reg_rdata is sampled RD_LAT edges after the reg_rd assertion edge, and d_valid rises on that sampling edge.
- reg_wdata: PutFull passes a_data through; PutPartial zeroes lanes where mask=0; reg_wdata is 0 when not writing.
- reg_addr and reg_byte return to 0 when no strobe is active.
- Denied Get returns d_opcode=1, d_data=0, d_denied=1.
- d_ready held high in IDLE has no effect.
- The queue keeps accepting requests while the FSM is stalled in RESP, until it is full.

Test Plan:
- PutFull addr 2, data 0xDEADBEEF, src 3: expect reg_wr one cycle with reg_addr=2, reg_byte=0xF, reg_wdata=0xDEADBEEF; then D opcode 0, source 3, denied 0, two edges after accept.
- PutPartial mask 4'b0101, data 0x11223344: expect reg_byte=0x5, reg_wdata=0x00220044.
- Get addr 5 with RD_LAT=2, model returns 0xCAFEF00D two cycles after reg_rd: expect D opcode 1, data 0xCAFEF00D, d_valid rising at edge 3 after accept.
- DEPTH=2, d_ready low for 10 cycles, 4 back-to-back Gets with src 1..4: expect 1 in service plus 2 queued, so a_ready low after the 3rd accept. After d_ready rises, responses come in src order 1,2,3,4 and fields are stable while stalled.
- Opcode 7 and Put to addr REG_NUM: expect no reg_wr/reg_rd and d_denied=1 with d_opcode 0. Get to addr REG_NUM: expect d_opcode 1, d_data 0, d_denied 1.
- Assert rst_n low while in RESP with 1 request queued: expect d_valid, the strobes and the queue all cleared immediately. After release, no stale response appears and a_ready=1.

Source files
------------

// File: rtl/tl_ul_slave_q.sv
// tl_ul_slave_q: TileLink-UL slave in front of a simple register-file port.
// Channel A requests go into a DEPTH-entry FIFO. A single FSM takes them one
// at a time in order: it issues a one-cycle reg_wr/reg_rd strobe, waits out the
// read latency, then holds the channel D response until it is accepted.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source keeps valid and its payload
// stable until that transfer. Valid does not depend on ready. The slave keeps
// every D field stable while d_valid is high and d_ready is low. a_ready
// depends only on the queue occupancy. d_valid depends only on the FSM state.
module tl_ul_slave_q #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int SW      = 4,
  parameter int DEPTH   = 2,
  parameter int RD_LAT  = 1,
  parameter int REG_NUM = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  // channel A
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [2:0]      a_opcode,
  input  logic [DW/8-1:0] a_mask,
  input  logic [AW-1:0]   a_address,
  input  logic [SW-1:0]   a_source,
  input  logic [DW-1:0]   a_data,
  // channel D
  output logic            d_valid,
  input  logic            d_ready,
  output logic [2:0]      d_opcode,
  output logic [SW-1:0]   d_source,
  output logic            d_denied,
  output logic [DW-1:0]   d_data,
  // register-file port
  output logic            reg_wr,
  output logic            reg_rd,
  output logic [AW-1:0]   reg_addr,
  output logic [DW/8-1:0] reg_byte,
  output logic [DW-1:0]   reg_wdata,
  input  logic [DW-1:0]   reg_rdata
);

  localparam int MW = DW / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [31:0]   REG_LIMIT = 32'(REG_NUM);
  // The WAIT state counts 0 .. RD_LAT-2. The value is only used when RD_LAT > 1.
  localparam int            WAIT_LAST_I = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
  localparam logic [1:0]    WAIT_LAST   = 2'(WAIT_LAST_I);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [2:0]    q_op   [DEPTH];
  logic [MW-1:0] q_mask [DEPTH];
  logic [AW-1:0] q_addr [DEPTH];
  logic [SW-1:0] q_src  [DEPTH];
  logic [DW-1:0] q_data [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  logic [2:0]    head_op;
  logic [MW-1:0] head_mask;
  logic [AW-1:0] head_addr;
  logic [SW-1:0] head_src;
  logic [DW-1:0] head_data;
  logic          head_op_ok;
  logic          head_addr_ok;
  logic          head_denied;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [MW-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < MW; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  // a_ready is held low during reset so nothing is pushed into a cleared queue.
  assign a_ready = rst_n & (count_q < DEPTH_C);
  assign push    = a_valid & a_ready;

  assign head_op   = q_op[rd_ptr_q];
  assign head_mask = q_mask[rd_ptr_q];
  assign head_addr = q_addr[rd_ptr_q];
  assign head_src  = q_src[rd_ptr_q];
  assign head_data = q_data[rd_ptr_q];

  assign head_op_ok   = (head_op == OP_PUT_FULL) || (head_op == OP_PUT_PART) ||
                        (head_op == OP_GET);
  assign head_addr_ok = (32'(head_addr) < REG_LIMIT);
  assign head_denied  = !(head_op_ok && head_addr_ok);

  // Compute the FIFO pointer and occupancy updates for a push, a pop, or both.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register the FIFO pointers and occupancy. Reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write payload storage. The pointers define validity, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr_q]   <= a_opcode;
      q_mask[wr_ptr_q] <= a_mask;
      q_addr[wr_ptr_q] <= a_address;
      q_src[wr_ptr_q]  <= a_source;
      q_data[wr_ptr_q] <= a_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Service FSM and latched transaction
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic          rd_legal_q, rd_legal_d;   // legal Get: a read must be captured
  logic          dop_q, dop_d;             // 1 -> AccessAckData
  logic          denied_q, denied_d;
  logic [SW-1:0] src_q, src_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;

  logic          reg_wr_q, reg_wr_d;
  logic          reg_rd_q, reg_rd_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic [MW-1:0] reg_byte_q, reg_byte_d;
  logic [DW-1:0] reg_wdata_q, reg_wdata_d;

  // Next-state logic. The strobe signals are only set on the pop edge, so they
  // fall back to zero on the following edge.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    rd_legal_d  = rd_legal_q;
    dop_d       = dop_q;
    denied_d    = denied_q;
    src_d       = src_q;
    rdata_d     = rdata_q;
    wait_cnt_d  = wait_cnt_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_addr_d  = '0;
    reg_byte_d  = '0;
    reg_wdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          state_d    = ACCESS;
          dop_d      = (head_op == OP_GET);
          denied_d   = head_denied;
          src_d      = head_src;
          rdata_d    = '0;
          rd_legal_d = (head_op == OP_GET) && !head_denied;
          if (!head_denied) begin
            reg_addr_d = head_addr;
            if (head_op == OP_GET) begin
              reg_rd_d   = 1'b1;
              reg_byte_d = '1;
            end else begin
              reg_wr_d    = 1'b1;
              reg_byte_d  = (head_op == OP_PUT_PART) ? head_mask : '1;
              reg_wdata_d = head_data & lane_mask(reg_byte_d);
            end
          end
        end
      end
      ACCESS: begin
        if (rd_legal_q) begin
          if (RD_LAT > 1) begin
            state_d    = WAIT;
            wait_cnt_d = '0;
          end else begin
            rdata_d = reg_rdata;
            state_d = RESP;
          end
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          rdata_d = reg_rdata;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (d_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register the FSM state, the latched transaction, and the register-port
  // outputs. Reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_legal_q  <= 1'b0;
      dop_q       <= 1'b0;
      denied_q    <= 1'b0;
      src_q       <= '0;
      rdata_q     <= '0;
      wait_cnt_q  <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_byte_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_legal_q  <= rd_legal_d;
      dop_q       <= dop_d;
      denied_q    <= denied_d;
      src_q       <= src_d;
      rdata_q     <= rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      reg_addr_q  <= reg_addr_d;
      reg_byte_q  <= reg_byte_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // D fields are gated by d_valid so the channel reads all-zero when idle.
  // rdata_q is only loaded for legal Gets, so d_data is 0 for every other kind
  // of response.
  assign d_valid   = (state_q == RESP);
  assign d_opcode  = d_valid ? {2'b00, dop_q} : 3'b000;
  assign d_source  = d_valid ? src_q : '0;
  assign d_denied  = d_valid & denied_q;
  assign d_data    = d_valid ? rdata_q : '0;

  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = reg_addr_q;
  assign reg_byte  = reg_byte_q;
  assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_tl_ul_slave_q.sv
// tb_tl_ul_slave_q: directed checks of tl_ul_slave_q. The DUT uses a two-cycle
// read latency and 12 implemented registers, so address 12 is out of range.
module tb_tl_ul_slave_q;

  localparam int DW      = 32;
  localparam int AW      = 4;
  localparam int SW      = 4;
  localparam int MW      = DW / 8;
  localparam int DEPTH   = 2;
  localparam int RD_LAT  = 2;
  localparam int REG_NUM = 12;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_valid, a_ready;
  logic [2:0]    a_opcode;
  logic [MW-1:0] a_mask;
  logic [AW-1:0] a_address;
  logic [SW-1:0] a_source;
  logic [DW-1:0] a_data;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode;
  logic [SW-1:0] d_source;
  logic          d_denied;
  logic [DW-1:0] d_data;
  logic          reg_wr, reg_rd;
  logic [AW-1:0] reg_addr;
  logic [MW-1:0] reg_byte;
  logic [DW-1:0] reg_wdata, reg_rdata;

  tl_ul_slave_q #(
    .DW(DW), .AW(AW), .SW(SW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .REG_NUM(REG_NUM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_mask(a_mask),
    .a_address(a_address), .a_source(a_source), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_byte(reg_byte),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // ---------------------------------------------------------------------------
  // Register bank: byte-masked writes. Read data appears one edge after the
  // strobe and is cleared on the next edge, so it is valid only at the edge
  // where RD_LAT=2 sampling should happen.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_pipe;
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[5]  <= 32'hCAFEF00D;
      mem[7]  <= 32'h12345678;
      rd_pipe <= '0;
    end else begin
      if (reg_wr) begin
        for (int b = 0; b < MW; b++) begin
          if (reg_byte[b]) mem[reg_addr][b*8 +: 8] <= reg_wdata[b*8 +: 8];
        end
      end
      rd_pipe <= reg_rd ? mem[reg_addr] : '0;
    end
  end
  assign reg_rdata = rd_pipe;

  always @(posedge clk) begin
    if (reg_wr) wr_cnt++;
    if (reg_rd) rd_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [SW+DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [2:0] op, input logic [MW-1:0] mask,
                      input logic [AW-1:0] addr, input logic [SW-1:0] src,
                      input logic [DW-1:0] data);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_mask    = mask;
    a_address = addr;
    a_source  = src;
    a_data    = data;
    for (int i = 0; i < 50 && !a_ready; i++) begin
      @(posedge clk); #1;
    end
    check_eq("send_ready", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  // Sends one request with d_ready high and checks the strobe cycle, the cycle
  // in which d_valid rises (resp_edge edges after accept), and the handshake.
  task automatic do_txn(input string tag, input logic [2:0] op,
                        input logic [MW-1:0] mask, input logic [AW-1:0] addr,
                        input logic [SW-1:0] src, input logic [DW-1:0] data,
                        input logic exp_wr, input logic exp_rd,
                        input logic [AW-1:0] exp_addr, input logic [MW-1:0] exp_byte,
                        input logic [DW-1:0] exp_wdata, input int resp_edge,
                        input logic [2:0] exp_dop, input logic exp_den,
                        input logic [DW-1:0] exp_ddata);
    send(op, mask, addr, src, data);
    @(posedge clk); #1;
    check_eq({tag, "_wr"},    reg_wr,    exp_wr);
    check_eq({tag, "_rd"},    reg_rd,    exp_rd);
    check_eq({tag, "_addr"},  reg_addr,  exp_addr);
    check_eq({tag, "_byte"},  reg_byte,  exp_byte);
    check_eq({tag, "_wdata"}, reg_wdata, exp_wdata);
    check_eq({tag, "_dv_e1"}, d_valid,   0);
    for (int e = 2; e <= resp_edge; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        check_eq({tag, "_strobe_off"}, {reg_wr, reg_rd}, 0);
        check_eq({tag, "_addr_off"},   {reg_addr, reg_byte, reg_wdata}, 0);
      end
      if (e < resp_edge) check_eq({tag, "_dv_early"}, d_valid, 0);
    end
    check_eq({tag, "_dvalid"},  d_valid,  1);
    check_eq({tag, "_dopcode"}, d_opcode, exp_dop);
    check_eq({tag, "_dsource"}, d_source, src);
    check_eq({tag, "_ddenied"}, d_denied, exp_den);
    check_eq({tag, "_ddata"},   d_data,   exp_ddata);
    @(posedge clk); #1;
    check_eq({tag, "_done"}, d_valid, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int got_cnt;
  int acc4;
  int changes;
  int ready_leaks;
  int stale;
  int wr0;
  int rd0;
  bit seen;
  logic [SW-1:0] s_src;
  logic [DW-1:0] s_data;
  logic [SW+DW-1:0] exp_e;

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_mask = '0; a_address = '0;
    a_source = '0; a_data = '0; d_ready = 1'b1;

    // Reset state
    #2;
    check_eq("rst_a_ready", a_ready, 0);
    check_eq("rst_d_valid", d_valid, 0);
    check_eq("rst_strobes", {reg_wr, reg_rd}, 0);
    check_eq("rst_d_fields", {d_opcode, d_source, d_denied, d_data}, 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_a_ready", a_ready, 1);

    // Legal single transactions
    do_txn("pfull", 3'd0, 4'hF, 4'd2, 4'd3, 32'hDEADBEEF,
           1'b1, 1'b0, 4'd2, 4'hF, 32'hDEADBEEF, 2, 3'd0, 1'b0, 32'h0);
    do_txn("ppart", 3'd1, 4'b0101, 4'd3, 4'd5, 32'h11223344,
           1'b1, 1'b0, 4'd3, 4'h5, 32'h00220044, 2, 3'd0, 1'b0, 32'h0);
    do_txn("get", 3'd4, 4'h0, 4'd5, 4'd6, 32'h0,
           1'b0, 1'b1, 4'd5, 4'hF, 32'h0, 3, 3'd1, 1'b0, 32'hCAFEF00D);

    // Denied requests: no strobes at all
    wr0 = wr_cnt; rd0 = rd_cnt;
    do_txn("op7", 3'd7, 4'hF, 4'd1, 4'd8, 32'h55AA55AA,
           1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 2, 3'd0, 1'b1, 32'h0);
    do_txn("put_oor", 3'd0, 4'hF, 4'd12, 4'd9, 32'h01020304,
           1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 2, 3'd0, 1'b1, 32'h0);
    do_txn("get_oor", 3'd4, 4'hF, 4'd12, 4'd10, 32'h0,
           1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 2, 3'd1, 1'b1, 32'h0);
    check_eq("den_wr_cnt", wr_cnt, wr0);
    check_eq("den_rd_cnt", rd_cnt, rd0);

    // Back-to-back Gets under back-pressure: 1 in service + 2 queued
    d_ready = 1'b0;
    exp_q.push_back({4'd1, 32'hDEADBEEF});
    exp_q.push_back({4'd2, 32'h00220044});
    exp_q.push_back({4'd3, 32'hCAFEF00D});
    exp_q.push_back({4'd4, 32'h12345678});
    send(3'd4, 4'hF, 4'd2, 4'd1, 32'h0);
    send(3'd4, 4'hF, 4'd3, 4'd2, 32'h0);
    send(3'd4, 4'hF, 4'd5, 4'd3, 32'h0);
    check_eq("q_full_ready", a_ready, 0);
    a_valid = 1'b1; a_opcode = 3'd4; a_mask = 4'hF; a_address = 4'd7;
    a_source = 4'd4; a_data = '0;
    changes = 0; ready_leaks = 0; seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (a_ready) ready_leaks++;
      if (d_valid) begin
        if (!seen) begin
          seen = 1'b1; s_src = d_source; s_data = d_data;
        end else if (d_source !== s_src || d_data !== s_data || d_opcode !== 3'd1) begin
          changes++;
        end
      end else if (seen) begin
        changes++;
      end
    end
    check_eq("stall_ready_leaks", ready_leaks, 0);
    check_eq("stall_changes", changes, 0);
    check_eq("stall_dvalid", d_valid, 1);
    check_eq("stall_src", d_source, 4'd1);
    check_eq("stall_data", d_data, 32'hDEADBEEF);

    d_ready = 1'b1;
    got_cnt = 0; acc4 = 0;
    fork
      begin
        for (int c = 0; c < 150 && got_cnt < 4; c++) begin
          @(negedge clk);
          if (d_valid && d_ready) begin
            exp_e = exp_q.pop_front();
            check_eq("order_src",  d_source, exp_e[SW+DW-1:DW]);
            check_eq("order_data", d_data,   exp_e[DW-1:0]);
            check_eq("order_op",   d_opcode, 3'd1);
            got_cnt++;
          end
        end
      end
      begin
        for (int c = 0; c < 100 && acc4 == 0; c++) begin
          @(negedge clk);
          if (a_ready) acc4 = 1;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
      end
    join
    check_eq("order_count", got_cnt, 4);
    check_eq("q4_accepted", acc4, 1);
    @(posedge clk); #1;
    check_eq("drain_idle", {d_valid, a_ready}, 2'b01);

    // Reset while in RESP with one request still queued
    d_ready = 1'b0;
    send(3'd0, 4'hF, 4'd4, 4'd11, 32'hAAAA5555);
    send(3'd0, 4'hF, 4'd6, 4'd12, 32'h5555AAAA);
    @(posedge clk); #1;
    check_eq("rstq_pre_dvalid", d_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rstq_dvalid", d_valid, 0);
    check_eq("rstq_strobes", {reg_wr, reg_rd}, 0);
    check_eq("rstq_a_ready_low", a_ready, 0);
    wr0 = wr_cnt; rd0 = rd_cnt;
    #3 rst_n = 1'b1;
    d_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (d_valid || reg_wr || reg_rd) stale++;
    end
    check_eq("rstq_stale", stale, 0);
    check_eq("rstq_wr_cnt", wr_cnt, wr0);
    check_eq("rstq_rd_cnt", rd_cnt, rd0);
    check_eq("rstq_a_ready", a_ready, 1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
